// File: rtl/alu_seq.sv
// Registered ALU with start/busy/done handshake: single-cycle arithmetic and logic,
// iterative shift/rotate and shift-add multiply, optional carry chaining via the stored carry flag.
module alu_seq #(
    parameter int WIDTH         = 64,
    parameter bit CIN_FROM_FLAG = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] o,
    output logic             cout,
    output logic             oflow,
    output logic             ntive,
    output logic             zero
);

    localparam int SW = $clog2(WIDTH);
    localparam int CW = SW + 1;

    typedef enum logic {IDLE, RUN} state_t;

    state_t           state, state_n;
    logic [3:0]       op_r, op_r_n;
    logic [WIDTH-1:0] acc, acc_n;
    logic [WIDTH-1:0] lo, lo_n;
    logic [WIDTH-1:0] mcand, mcand_n;
    logic [CW-1:0]    cnt, cnt_n;
    logic [WIDTH-1:0] o_n;
    logic             cout_n, oflow_n, ntive_n, zero_n, done_n;

    logic             c;
    logic [WIDTH:0]   ax, bx, r;
    logic [SW-1:0]    k;
    logic [WIDTH-1:0] s_o;
    logic             s_c, s_v, s_n, s_z;
    logic [WIDTH-1:0] step_acc;
    logic             step_bit;
    logic [WIDTH:0]   madd;
    logic [WIDTH-1:0] fin_o;
    logic             fin_c;

    assign c    = CIN_FROM_FLAG ? cout : cin;
    assign ax   = {1'b0, a};
    assign bx   = {1'b0, b};
    assign k    = b[SW-1:0];
    assign busy = (state == RUN);

    // Single-cycle datapath; shift/rotate ops reach here only with k=0 and pass A through.
    always_comb begin
        r = ax;
        case (op)
            4'h1: r = bx;
            4'h2: r = ax + bx;
            4'h3: r = ax + bx + {{WIDTH{1'b0}}, c};
            4'h4: r = ax - bx;
            4'h5: r = ax - bx + {{WIDTH{1'b0}}, c};
            4'h6: r = bx - ax;
            4'h7: r = bx - ax + {{WIDTH{1'b0}}, c};
            4'h8: r = ax - bx;
            4'h9: r = {1'b0, a & b};
            4'hA: r = {1'b0, a | b};
            4'hB: r = {1'b0, a ^ b};
            default: r = ax;
        endcase

        s_v = 1'b0;
        case (op)
            4'h2, 4'h3:       s_v = (a[WIDTH-1] == b[WIDTH-1]) && (r[WIDTH-1] != a[WIDTH-1]);
            4'h4, 4'h5, 4'h8: s_v = (a[WIDTH-1] != b[WIDTH-1]) && (r[WIDTH-1] != a[WIDTH-1]);
            4'h6, 4'h7:       s_v = (a[WIDTH-1] != b[WIDTH-1]) && (r[WIDTH-1] != b[WIDTH-1]);
            default:          s_v = 1'b0;
        endcase

        s_c = (op >= 4'h2 && op <= 4'h8) ? r[WIDTH] : 1'b0;
        if (op == 4'h8) begin
            s_o = '0;
            s_n = (a < b);
            s_z = (a == b);
        end else begin
            s_o = r[WIDTH-1:0];
            s_n = r[WIDTH-1];
            s_z = (r[WIDTH-1:0] == '0);
        end
    end

    // One iteration of the latched multi-cycle op; the MUL product accumulates in {acc, lo}.
    always_comb begin
        step_acc = acc;
        step_bit = 1'b0;
        case (op_r)
            4'hC: begin
                step_acc = {acc[WIDTH-2:0], 1'b0};
                step_bit = acc[WIDTH-1];
            end
            4'hD: begin
                step_acc = {1'b0, acc[WIDTH-1:1]};
                step_bit = acc[0];
            end
            4'hE: begin
                step_acc = {acc[WIDTH-2:0], acc[WIDTH-1]};
                step_bit = acc[WIDTH-1];
            end
            default: begin
                step_acc = acc;
                step_bit = 1'b0;
            end
        endcase
        madd = {1'b0, acc} + (lo[0] ? {1'b0, mcand} : '0);
    end

    // Next-state and output-register logic; outputs only move together with done.
    always_comb begin
        state_n = state;
        op_r_n  = op_r;
        acc_n   = acc;
        lo_n    = lo;
        mcand_n = mcand;
        cnt_n   = cnt;
        o_n     = o;
        cout_n  = cout;
        oflow_n = oflow;
        ntive_n = ntive;
        zero_n  = zero;
        done_n  = 1'b0;
        fin_o   = '0;
        fin_c   = 1'b0;

        case (state)
            IDLE: begin
                if (start) begin
                    if (op == 4'hF) begin
                        state_n = RUN;
                        op_r_n  = op;
                        acc_n   = '0;
                        lo_n    = b;
                        mcand_n = a;
                        cnt_n   = CW'(WIDTH);
                    end else if (op >= 4'hC && k != '0) begin
                        state_n = RUN;
                        op_r_n  = op;
                        acc_n   = a;
                        cnt_n   = {1'b0, k};
                    end else begin
                        o_n     = s_o;
                        cout_n  = s_c;
                        oflow_n = s_v;
                        ntive_n = s_n;
                        zero_n  = s_z;
                        done_n  = 1'b1;
                    end
                end
            end
            RUN: begin
                cnt_n = cnt - CW'(1);
                if (op_r == 4'hF) begin
                    acc_n = madd[WIDTH:1];
                    lo_n  = {madd[0], lo[WIDTH-1:1]};
                    fin_o = {madd[0], lo[WIDTH-1:1]};
                    fin_c = |madd[WIDTH:1];
                end else begin
                    acc_n = step_acc;
                    fin_o = step_acc;
                    fin_c = step_bit;
                end
                if (cnt == CW'(1)) begin
                    state_n = IDLE;
                    done_n  = 1'b1;
                    o_n     = fin_o;
                    cout_n  = fin_c;
                    oflow_n = (op_r == 4'hF) ? fin_c : 1'b0;
                    ntive_n = fin_o[WIDTH-1];
                    zero_n  = (fin_o == '0);
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // State register; reset aborts any operation in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            op_r  <= '0;
            acc   <= '0;
            lo    <= '0;
            mcand <= '0;
            cnt   <= '0;
            o     <= '0;
            cout  <= 1'b0;
            oflow <= 1'b0;
            ntive <= 1'b0;
            zero  <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= state_n;
            op_r  <= op_r_n;
            acc   <= acc_n;
            lo    <= lo_n;
            mcand <= mcand_n;
            cnt   <= cnt_n;
            o     <= o_n;
            cout  <= cout_n;
            oflow <= oflow_n;
            ntive <= ntive_n;
            zero  <= zero_n;
            done  <= done_n;
        end
    end

endmodule
